// File: rtl/mem_arbiter_pkg.sv
// Shared types for the imem/dmem memory-bus arbiter: bus records, FSM state, register image.
package mem_arbiter_pkg;

  typedef struct packed {
    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
  } mem_in_type;

  typedef struct packed {
    logic        mem_ready;
    logic [31:0] mem_rdata;
  } mem_out_type;

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} mem_arbiter_state_type;
  typedef enum logic {PORT_I = 1'b0, PORT_D = 1'b1} mem_arbiter_port_type;

  typedef struct packed {
    mem_arbiter_state_type state;
    mem_in_type            islot;
    mem_in_type            dslot;
    logic                  ivld;
    logic                  dvld;
    mem_arbiter_port_type  rr_last;
    logic                  prot_err;
  } mem_arbiter_reg_type;

  localparam mem_arbiter_reg_type init_mem_arbiter_reg = '{
    state: IDLE, islot: '0, dslot: '0, ivld: 1'b0, dvld: 1'b0,
    rr_last: PORT_D, prot_err: 1'b0};

endpackage

// File: rtl/mem_arbiter_slot.sv
// One-deep request holding register with full flag; one instance per requesting port.
module mem_arbiter_slot
  import mem_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       clr,
  input  mem_in_type req,
  output logic       full,
  output mem_in_type data
);

  // load only happens while empty and clr only while full, so they never collide
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full <= 1'b0;
      data <= '0;
    end else if (load) begin
      full <= 1'b1;
      data <= req;
    end else if (clr) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates fetch (imem) and data (dmem) requests onto one memory bus, one transaction at a time.
// Define MEM_ARBITER_RR_EN for round-robin tie-breaking; otherwise dmem always wins a tie.
module mem_arbiter
  import mem_arbiter_pkg::*;
(
  input  logic        rst,
  input  logic        clk,
  input  mem_in_type  imem_in,
  output mem_out_type imem_out,
  input  mem_in_type  dmem_in,
  output mem_out_type dmem_out,
  output mem_in_type  mem_out,
  input  mem_out_type mem_in,
  output logic        prot_err
);

  mem_arbiter_state_type state;
  logic       ifull, dfull;
  mem_in_type islot, dslot;
  logic       err_i, err_d, load_i, load_d, grant_i, grant_d;

  // A port may have at most one request outstanding (held or on the bus)
  assign err_i  = imem_in.mem_valid && (ifull || state == BUSY_I);
  assign err_d  = dmem_in.mem_valid && (dfull || state == BUSY_D);
  assign load_i = imem_in.mem_valid && !err_i;
  assign load_d = dmem_in.mem_valid && !err_d;

`ifdef MEM_ARBITER_RR_EN
  mem_arbiter_port_type rr_last;
  assign grant_d = (state == IDLE) && dfull && (!ifull || rr_last == PORT_I);
`else
  assign grant_d = (state == IDLE) && dfull;
`endif
  assign grant_i = (state == IDLE) && ifull && !grant_d;

  mem_arbiter_slot u_islot (
    .clk(clk), .rst(rst), .load(load_i), .clr(grant_i), .req(imem_in),
    .full(ifull), .data(islot));

  mem_arbiter_slot u_dslot (
    .clk(clk), .rst(rst), .load(load_d), .clr(grant_d), .req(dmem_in),
    .full(dfull), .data(dslot));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= init_mem_arbiter_reg.state;
      prot_err <= init_mem_arbiter_reg.prot_err;
      mem_out  <= '0;
      imem_out <= '0;
      dmem_out <= '0;
`ifdef MEM_ARBITER_RR_EN
      rr_last  <= init_mem_arbiter_reg.rr_last;
`endif
    end else begin
      imem_out.mem_ready <= 1'b0;
      dmem_out.mem_ready <= 1'b0;
      if (err_i || err_d) prot_err <= 1'b1;
      case (state)
        IDLE: begin
          if (grant_d) begin
            mem_out           <= dslot;
            mem_out.mem_valid <= 1'b1;
            mem_out.mem_instr <= 1'b0;
            state             <= BUSY_D;
`ifdef MEM_ARBITER_RR_EN
            rr_last           <= PORT_D;
`endif
          end else if (grant_i) begin
            mem_out           <= islot;
            mem_out.mem_valid <= 1'b1;
            mem_out.mem_instr <= 1'b1;
            state             <= BUSY_I;
`ifdef MEM_ARBITER_RR_EN
            rr_last           <= PORT_I;
`endif
          end
        end
        BUSY_I: if (mem_in.mem_ready) begin
          mem_out.mem_valid  <= 1'b0;
          imem_out.mem_ready <= 1'b1;
          imem_out.mem_rdata <= mem_in.mem_rdata;
          state              <= IDLE;
        end
        BUSY_D: if (mem_in.mem_ready) begin
          mem_out.mem_valid  <= 1'b0;
          dmem_out.mem_ready <= 1'b1;
          dmem_out.mem_rdata <= mem_in.mem_rdata;
          state              <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
